// File: rtl/uart_cmd_decoder.sv
// Command-frame decoder behind the UART receiver: assembles AA/BB/CC/DD frames
// into register-file and ALU strobes, with an inter-byte timeout to abort stale frames.
module uart_cmd_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  CMD_ERR,
  output logic                  FRAME_ERR,
  output logic                  BUSY
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_F
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);
  // Expiry fires in the idle cycle that would push the count to TIMEOUT.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t                  state, state_n;
  logic [15:0]             cnt, cnt_n;
  logic                    wr_n, rd_n, alu_n, cmd_err_n, frame_err_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [DATA_WIDTH-1:0]   wdata_n;
  logic [3:0]              fun_n;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      ALU_EN     <= 1'b0;
      CMD_ERR    <= 1'b0;
      FRAME_ERR  <= 1'b0;
      RF_Address <= '0;
      RF_WrData  <= '0;
      ALU_FUN    <= '0;
      BUSY       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      RF_WrEn    <= wr_n;
      RF_RdEn    <= rd_n;
      ALU_EN     <= alu_n;
      CMD_ERR    <= cmd_err_n;
      FRAME_ERR  <= frame_err_n;
      RF_Address <= addr_n;
      RF_WrData  <= wdata_n;
      ALU_FUN    <= fun_n;
      BUSY       <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = '0;
    wr_n        = 1'b0;
    rd_n        = 1'b0;
    alu_n       = 1'b0;
    cmd_err_n   = 1'b0;
    frame_err_n = 1'b0;
    addr_n      = RF_Address;
    wdata_n     = RF_WrData;
    fun_n       = ALU_FUN;

    if (RX_D_VLD) begin
      unique case (state)
        IDLE: begin
          if      (RX_P_DATA == CMD_WR)  state_n = WR_ADDR;
          else if (RX_P_DATA == CMD_RD)  state_n = RD_ADDR;
          else if (RX_P_DATA == CMD_ALU) state_n = ALU_A;
          else if (RX_P_DATA == CMD_FUN) state_n = ALU_F;
          else                           cmd_err_n = 1'b1;
        end
        WR_ADDR: begin
          addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_n = WR_DATA;
        end
        WR_DATA: begin
          wdata_n = RX_P_DATA;
          wr_n    = 1'b1;
          state_n = IDLE;
        end
        RD_ADDR: begin
          addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_n    = 1'b1;
          state_n = IDLE;
        end
        ALU_A: begin
          addr_n  = ADDR_WIDTH'(0);
          wdata_n = RX_P_DATA;
          wr_n    = 1'b1;
          state_n = ALU_B;
        end
        ALU_B: begin
          addr_n  = ADDR_WIDTH'(1);
          wdata_n = RX_P_DATA;
          wr_n    = 1'b1;
          state_n = ALU_F;
        end
        ALU_F: begin
          fun_n   = RX_P_DATA[3:0];
          alu_n   = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (cnt == CNT_LAST) begin
        frame_err_n = 1'b1;
        state_n     = IDLE;
      end else begin
        cnt_n = cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed vector table on a default-timeout instance,
// timeout/reset sequences and a randomized run against a frame-level model (TIMEOUT=8).
module tb_uart_cmd_decoder;

  localparam int TO8 = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;

  logic       m_wr, m_rd, m_alu, m_cmd, m_ferr, m_busy;
  logic [3:0] m_addr, m_fun;
  logic [7:0] m_wd;
  logic       t_wr, t_rd, t_alu, t_cmd, t_ferr, t_busy;
  logic [3:0] t_addr, t_fun;
  logic [7:0] t_wd;

  always #5 CLK = ~CLK;

  uart_cmd_decoder dut_m (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_WrEn(m_wr), .RF_RdEn(m_rd), .RF_Address(m_addr), .RF_WrData(m_wd),
    .ALU_EN(m_alu), .ALU_FUN(m_fun), .CMD_ERR(m_cmd), .FRAME_ERR(m_ferr), .BUSY(m_busy)
  );

  uart_cmd_decoder #(.TIMEOUT(TO8)) dut_t (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_WrEn(t_wr), .RF_RdEn(t_rd), .RF_Address(t_addr), .RF_WrData(t_wd),
    .ALU_EN(t_alu), .ALU_FUN(t_fun), .CMD_ERR(t_cmd), .FRAME_ERR(t_ferr), .BUSY(t_busy)
  );

  // {wr, rd, alu, cmd_err, frame_err, busy, addr, wdata, fun}
  logic [21:0] m_out, t_out;
  assign m_out = {m_wr, m_rd, m_alu, m_cmd, m_ferr, m_busy, m_addr, m_wd, m_fun};
  assign t_out = {t_wr, t_rd, t_alu, t_cmd, t_ferr, t_busy, t_addr, t_wd, t_fun};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d);
    RX_D_VLD  = v;
    RX_P_DATA = d;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
  endtask

  function automatic logic [21:0] pk(input logic wr, rd, alu, cmd, ferr, busy,
                                     input logic [3:0] addr, input logic [7:0] wd,
                                     input logic [3:0] fun);
    return {wr, rd, alu, cmd, ferr, busy, addr, wd, fun};
  endfunction

  typedef struct {
    int         gap;
    logic [7:0] d;
    logic       wr, rd, alu, cmd, busy;
    logic [3:0] addr;
    logic [7:0] wd;
    logic [3:0] fun;
  } vec_t;

  // Frame-level reference: the bytes of the frame in progress plus an idle count.
  logic [7:0] frame[$];
  int         idle;
  logic       e_wr, e_rd, e_alu, e_cmd, e_ferr;
  logic [3:0] e_addr, e_fun;
  logic [7:0] e_wd;

  function automatic bit is_cmd(input logic [7:0] b);
    return b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD;
  endfunction

  task automatic model_step(input logic v, input logic [7:0] d);
    int n;
    {e_wr, e_rd, e_alu, e_cmd, e_ferr} = '0;
    if (v) begin
      idle = 0;
      if (frame.size() == 0) begin
        if (is_cmd(d)) frame.push_back(d);
        else e_cmd = 1'b1;
      end else begin
        frame.push_back(d);
        n = frame.size();
        case (frame[0])
          8'hAA: if (n == 2) e_addr = d[3:0];
                 else begin e_wd = d; e_wr = 1'b1; frame.delete(); end
          8'hBB: begin e_addr = d[3:0]; e_rd = 1'b1; frame.delete(); end
          8'hCC: if (n == 2) begin e_addr = 4'd0; e_wd = d; e_wr = 1'b1; end
                 else if (n == 3) begin e_addr = 4'd1; e_wd = d; e_wr = 1'b1; end
                 else begin e_fun = d[3:0]; e_alu = 1'b1; frame.delete(); end
          default: begin e_fun = d[3:0]; e_alu = 1'b1; frame.delete(); end
        endcase
      end
    end else if (frame.size() != 0) begin
      idle++;
      if (idle == TO8) begin
        e_ferr = 1'b1;
        idle   = 0;
        frame.delete();
      end
    end
  endtask

  initial begin
    vec_t tbl[16];
    logic pbusy;
    int   k;
    bool_blk: begin end

    tbl[0]  = '{0,  8'hAA, 0,0,0,0,1, 4'h0, 8'h00, 4'h0};
    tbl[1]  = '{15, 8'h05, 0,0,0,0,1, 4'h5, 8'h00, 4'h0};
    tbl[2]  = '{15, 8'h3C, 1,0,0,0,0, 4'h5, 8'h3C, 4'h0};
    tbl[3]  = '{2,  8'hBB, 0,0,0,0,1, 4'h5, 8'h3C, 4'h0};
    tbl[4]  = '{0,  8'h0F, 0,1,0,0,0, 4'hF, 8'h3C, 4'h0};
    tbl[5]  = '{1,  8'hCC, 0,0,0,0,1, 4'hF, 8'h3C, 4'h0};
    tbl[6]  = '{0,  8'h12, 1,0,0,0,1, 4'h0, 8'h12, 4'h0};
    tbl[7]  = '{0,  8'h34, 1,0,0,0,1, 4'h1, 8'h34, 4'h0};
    tbl[8]  = '{0,  8'h01, 0,0,1,0,0, 4'h1, 8'h34, 4'h1};
    tbl[9]  = '{0,  8'hDD, 0,0,0,0,1, 4'h1, 8'h34, 4'h1};
    tbl[10] = '{0,  8'hA7, 0,0,1,0,0, 4'h1, 8'h34, 4'h7};
    tbl[11] = '{3,  8'h55, 0,0,0,1,0, 4'h1, 8'h34, 4'h7};
    tbl[12] = '{0,  8'hAA, 0,0,0,0,1, 4'h1, 8'h34, 4'h7};
    tbl[13] = '{0,  8'h02, 0,0,0,0,1, 4'h2, 8'h34, 4'h7};
    tbl[14] = '{0,  8'hFF, 1,0,0,0,0, 4'h2, 8'hFF, 4'h7};
    tbl[15] = '{1,  8'hAA, 0,0,0,0,1, 4'h2, 8'hFF, 4'h7};

    RST = 1'b0; RX_D_VLD = 1'b0; RX_P_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_main", 32'(m_out), 32'd0);
    chk("reset_t8",   32'(t_out), 32'd0);
    RST = 1'b1;

    // Directed table on the default-timeout instance.
    pbusy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < tbl[i].gap; g++) begin
        cyc(1'b0, 8'h00);
        chk($sformatf("gap%0d", i), 32'({m_wr, m_rd, m_alu, m_cmd, m_ferr, m_busy}),
            32'({5'b0, pbusy}));
      end
      cyc(1'b1, tbl[i].d);
      chk($sformatf("vec%0d", i), 32'(m_out),
          32'(pk(tbl[i].wr, tbl[i].rd, tbl[i].alu, tbl[i].cmd, 1'b0, tbl[i].busy,
                 tbl[i].addr, tbl[i].wd, tbl[i].fun)));
      pbusy = tbl[i].busy;
    end
    cyc(1'b0, 8'h00);
    chk("cmd_err_width", 32'({m_wr, m_cmd}), 32'd0);

    // Timeout on the TIMEOUT=8 instance: FRAME_ERR lands 8 edges after the last byte.
    RST = 1'b0; @(posedge CLK); #1; RST = 1'b1;
    cyc(1'b1, 8'hAA);
    cyc(1'b1, 8'h03);
    chk("to_addr", 32'({t_busy, t_addr}), 32'({1'b1, 4'h3}));
    k = 1;
    while (k <= 20) begin
      cyc(1'b0, 8'h00);
      if (t_ferr) break;
      k++;
    end
    chk("to_latency", 32'(k), 32'd8);
    chk("to_nostrobe", 32'({t_wr, t_rd, t_alu, t_busy}), 32'd0);
    cyc(1'b0, 8'h00);
    chk("to_width", 32'(t_ferr), 32'd0);

    // Byte arriving in the expiry cycle wins.
    cyc(1'b1, 8'hAA);
    cyc(1'b1, 8'h03);
    k = 0;
    for (int i = 0; i < TO8 - 1; i++) begin
      cyc(1'b0, 8'h00);
      if (t_ferr) k++;
    end
    cyc(1'b1, 8'h77);
    chk("to_win", 32'(t_out), 32'(pk(1,0,0,0,0,0, 4'h3, 8'h77, 4'h0)));
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 8'h00);
      if (t_ferr) k++;
    end
    chk("to_win_noerr", 32'(k), 32'd0);

    // Asynchronous reset mid-frame on the main instance.
    cyc(1'b1, 8'hCC);
    cyc(1'b1, 8'h11);
    chk("pre_reset", 32'(m_out), 32'(pk(1,0,0,0,0,1, 4'h0, 8'h11, 4'h0)));
    #2 RST = 1'b0;
    #1 chk("async_reset", 32'(m_out), 32'd0);
    @(posedge CLK); #1; RST = 1'b1;
    cyc(1'b1, 8'hDD);
    cyc(1'b1, 8'h02);
    chk("post_reset", 32'(m_out), 32'(pk(0,0,1,0,0,0, 4'h0, 8'h00, 4'h2)));

    // Randomized run on the TIMEOUT=8 instance against the frame model.
    RST = 1'b0; @(posedge CLK); #1; RST = 1'b1;
    frame.delete(); idle = 0;
    e_addr = '0; e_wd = '0; e_fun = '0;
    for (int i = 0; i < 500; i++) begin
      logic       v;
      logic [7:0] d;
      int         r;
      r = int'($urandom_range(0, 99));
      v = (r < 55);
      if (r >= 55 && r < 62 && frame.size() != 0) begin
        for (int g = 0; g < int'($urandom_range(5, 10)); g++) begin
          model_step(1'b0, 8'h00);
          cyc(1'b0, 8'h00);
          chk("rand_gap", 32'(t_out),
              32'(pk(e_wr, e_rd, e_alu, e_cmd, e_ferr, frame.size() != 0, e_addr, e_wd, e_fun)));
        end
      end
      case ($urandom_range(0, 5))
        0: d = 8'hAA;
        1: d = 8'hBB;
        2: d = 8'hCC;
        3: d = 8'hDD;
        default: d = 8'($urandom);
      endcase
      model_step(v, d);
      cyc(v, d);
      chk("rand", 32'(t_out),
          32'(pk(e_wr, e_rd, e_alu, e_cmd, e_ferr, frame.size() != 0, e_addr, e_wd, e_fun)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  always @(negedge CLK) begin
    if (RST && (int'(t_wr) + int'(t_rd) + int'(t_alu) > 1)) begin
      bad++;
      $display("FAIL onehot_strobes actual=%b required=at most one", {t_wr, t_rd, t_alu});
    end
  end

endmodule
